// File: rtl/transmissao_pkg.sv
// Shared types for the multichannel measurement transmitter: FSM states,
// byte phases and the index-width helper.
package transmissao_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CAPTURA,
        CONVERTE,
        ESPERA_CONVERTE,
        CARREGA,
        TRANSMITE,
        ESPERA_TX,
        PROXIMO,
        FIM
    } estado_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

    typedef enum logic [1:0] {
        DIGITO,
        SEPARADOR,
        TERMINADOR,
        CHECKSUM
    } fase_t;

    // Width of an index over n items, never less than one bit.
    function automatic int largura_idx(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/transmissao_medidas_fd.sv
// Datapath of the measurement transmitter: snapshot, channel mux, BCD latch,
// digit/channel/phase sequencing and byte selection (XOR checksum with TRANSMISSAO_CHECKSUM_EN).
module transmissao_medidas_fd
    import transmissao_pkg::*;
#(
    parameter int         NUM_CANAIS = 4,
    parameter int         MEDIDA_W   = 12,
    parameter int         DIGITOS    = 4,
    parameter logic [7:0] SEP_BYTE   = 8'h2C,
    parameter logic [7:0] TERM_BYTE  = 8'h23
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             i_captura,
    input  logic                             i_carrega_bcd,
    input  logic                             i_carrega_byte,
`ifdef TRANSMISSAO_CHECKSUM_EN
    input  logic                             i_enviado,
`endif
    input  logic                             i_avanca,
    input  logic [NUM_CANAIS*MEDIDA_W-1:0]   i_medidas,
    input  logic [4*DIGITOS-1:0]             i_bcd,
    output logic [MEDIDA_W-1:0]              o_medida_bin,
    output logic [7:0]                       o_byte,
    output logic [largura_idx(NUM_CANAIS)-1:0] o_canal,
    output logic                             o_vai_converter,
    output logic                             o_vai_fim
);

    localparam int CANAL_W = largura_idx(NUM_CANAIS);
    localparam int DIG_W   = largura_idx(DIGITOS);
    localparam logic [CANAL_W-1:0] CANAL_ULT = CANAL_W'(NUM_CANAIS - 1);
    localparam logic [DIG_W-1:0]   DIG_ULT   = DIG_W'(DIGITOS - 1);

    logic [NUM_CANAIS*MEDIDA_W-1:0] r_snap;
    logic [4*DIGITOS-1:0]           r_bcd;
    logic [CANAL_W-1:0]             r_canal;
    logic [DIG_W-1:0]               r_dig;
    fase_t                          r_fase;
    logic [7:0]                     r_byte;

    logic [MEDIDA_W-1:0] w_medida;
    logic [3:0]          w_nibble;
    logic [7:0]          w_byte_novo;
    logic [CANAL_W-1:0]  w_canal_prox;
    logic [DIG_W-1:0]    w_dig_prox;
    fase_t               w_fase_prox;
    logic                w_vai_converter;
    logic                w_vai_fim;

`ifdef TRANSMISSAO_CHECKSUM_EN
    logic [7:0] r_cks;
`endif

    always_comb begin
        w_medida = '0;
        for (int i = 0; i < NUM_CANAIS; i++) begin
            if (r_canal == CANAL_W'(i)) w_medida = r_snap[i*MEDIDA_W +: MEDIDA_W];
        end
    end

    // Digits go out most significant first: counter 0 picks nibble DIGITOS-1.
    always_comb begin
        w_nibble = '0;
        for (int i = 0; i < DIGITOS; i++) begin
            if (r_dig == DIG_W'(DIGITOS - 1 - i)) w_nibble = r_bcd[4*i +: 4];
        end
    end

    always_comb begin
        case (r_fase)
            DIGITO:     w_byte_novo = ASCII_ZERO + {4'b0000, w_nibble};
            SEPARADOR:  w_byte_novo = SEP_BYTE;
            TERMINADOR: w_byte_novo = TERM_BYTE;
`ifdef TRANSMISSAO_CHECKSUM_EN
            CHECKSUM:   w_byte_novo = r_cks;
`endif
            default:    w_byte_novo = 8'h00;
        endcase
    end

    always_comb begin
        w_fase_prox     = r_fase;
        w_dig_prox      = r_dig;
        w_canal_prox    = r_canal;
        w_vai_converter = 1'b0;
        w_vai_fim       = 1'b0;
        case (r_fase)
            DIGITO: begin
                if (r_dig < DIG_ULT) begin
                    w_dig_prox = r_dig + DIG_W'(1);
                end else if (r_canal < CANAL_ULT) begin
                    w_fase_prox = SEPARADOR;
                end else begin
`ifdef TRANSMISSAO_CHECKSUM_EN
                    w_fase_prox = CHECKSUM;
`else
                    w_fase_prox = TERMINADOR;
`endif
                end
            end
            SEPARADOR: begin
                w_fase_prox     = DIGITO;
                w_dig_prox      = '0;
                w_canal_prox    = r_canal + CANAL_W'(1);
                w_vai_converter = 1'b1;
            end
            CHECKSUM:   w_fase_prox = TERMINADOR;
            TERMINADOR: w_vai_fim   = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_snap  <= '0;
            r_bcd   <= '0;
            r_canal <= '0;
            r_dig   <= '0;
            r_fase  <= DIGITO;
            r_byte  <= '0;
        end else begin
            if (i_captura) begin
                r_snap  <= i_medidas;
                r_canal <= '0;
                r_dig   <= '0;
                r_fase  <= DIGITO;
            end else if (i_avanca) begin
                r_canal <= w_canal_prox;
                r_dig   <= w_dig_prox;
                r_fase  <= w_fase_prox;
            end
            if (i_carrega_bcd)  r_bcd  <= i_bcd;
            if (i_carrega_byte) r_byte <= w_byte_novo;
        end
    end

`ifdef TRANSMISSAO_CHECKSUM_EN
    // Only digits and separators feed the accumulator; checksum and terminator do not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cks <= '0;
        end else if (i_captura) begin
            r_cks <= '0;
        end else if (i_enviado && (r_fase == DIGITO || r_fase == SEPARADOR)) begin
            r_cks <= r_cks ^ r_byte;
        end
    end
`endif

    assign o_medida_bin    = w_medida;
    assign o_byte          = r_byte;
    assign o_canal         = r_canal;
    assign o_vai_converter = w_vai_converter;
    assign o_vai_fim       = w_vai_fim;

endmodule

// File: rtl/transmissao_medidas_multicanal.sv
// Transmit sequencer for multichannel measurement frames (BCD digits, separators, terminator).
// Optional XOR checksum byte before the terminator when TRANSMISSAO_CHECKSUM_EN is defined.
module transmissao_medidas_multicanal #(
    parameter int         NUM_CANAIS = 4,
    parameter int         MEDIDA_W   = 12,
    parameter int         DIGITOS    = 4,
    parameter logic [7:0] SEPARADOR  = 8'h2C,
    parameter logic [7:0] TERMINADOR = 8'h23
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  transmite,
    input  logic [NUM_CANAIS*MEDIDA_W-1:0]        medidas,
    output logic [MEDIDA_W-1:0]                   medida_bin,
    output logic                                  converte_bcd,
    input  logic [4*DIGITOS-1:0]                  bcd,
    input  logic                                  pronto_bcd,
    output logic                                  tx_partida,
    output logic [7:0]                            tx_dado,
    input  logic                                  tx_pronto,
    output logic                                  ocupado,
    output logic                                  pronto,
    output logic [transmissao_pkg::largura_idx(NUM_CANAIS)-1:0] canal
);
    import transmissao_pkg::*;

    estado_t r_estado;
    estado_t w_proximo;

    logic w_captura;
    logic w_carrega_bcd;
    logic w_carrega_byte;
    logic w_enviado;
    logic w_avanca;
    logic w_vai_converter;
    logic w_vai_fim;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_estado <= IDLE;
        else       r_estado <= w_proximo;
    end

    always_comb begin
        w_proximo      = r_estado;
        w_captura      = 1'b0;
        w_carrega_bcd  = 1'b0;
        w_carrega_byte = 1'b0;
        w_enviado      = 1'b0;
        w_avanca       = 1'b0;
        converte_bcd   = 1'b0;
        tx_partida     = 1'b0;
        pronto         = 1'b0;
        ocupado        = (r_estado != IDLE);
        case (r_estado)
            IDLE:            if (transmite) w_proximo = CAPTURA;
            CAPTURA: begin
                w_captura = 1'b1;
                w_proximo = CONVERTE;
            end
            CONVERTE: begin
                converte_bcd = 1'b1;
                w_proximo    = ESPERA_CONVERTE;
            end
            ESPERA_CONVERTE: begin
                if (pronto_bcd) begin
                    w_carrega_bcd = 1'b1;
                    w_proximo     = CARREGA;
                end
            end
            CARREGA: begin
                w_carrega_byte = 1'b1;
                w_proximo      = TRANSMITE;
            end
            TRANSMITE: begin
                tx_partida = 1'b1;
                w_enviado  = 1'b1;
                w_proximo  = ESPERA_TX;
            end
            ESPERA_TX:       if (tx_pronto) w_proximo = PROXIMO;
            PROXIMO: begin
                w_avanca = 1'b1;
                if (w_vai_fim)            w_proximo = FIM;
                else if (w_vai_converter) w_proximo = CONVERTE;
                else                      w_proximo = CARREGA;
            end
            FIM: begin
                pronto    = 1'b1;
                w_proximo = IDLE;
            end
            default:         w_proximo = IDLE;
        endcase
    end

    transmissao_medidas_fd #(
        .NUM_CANAIS (NUM_CANAIS),
        .MEDIDA_W   (MEDIDA_W),
        .DIGITOS    (DIGITOS),
        .SEP_BYTE   (SEPARADOR),
        .TERM_BYTE  (TERMINADOR)
    ) u_fd (
        .clock           (clock),
        .reset           (reset),
        .i_captura       (w_captura),
        .i_carrega_bcd   (w_carrega_bcd),
        .i_carrega_byte  (w_carrega_byte),
`ifdef TRANSMISSAO_CHECKSUM_EN
        .i_enviado       (w_enviado),
`endif
        .i_avanca        (w_avanca),
        .i_medidas       (medidas),
        .i_bcd           (bcd),
        .o_medida_bin    (medida_bin),
        .o_byte          (tx_dado),
        .o_canal         (canal),
        .o_vai_converter (w_vai_converter),
        .o_vai_fim       (w_vai_fim)
    );

`ifndef TRANSMISSAO_CHECKSUM_EN
    logic w_enviado_livre;
    assign w_enviado_livre = w_enviado;
`endif

endmodule

// File: tb/tb_transmissao_medidas_multicanal.sv
// Directed bench: default 4x4 instance plus a 1-channel/2-digit instance,
// with reactive BCD converter and TX models.
module tb_transmissao_medidas_multicanal;

    typedef logic [7:0] bq_t[$];

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        transmite = 1'b0;
    logic [47:0] medidas = '0;
    logic [11:0] medida_bin;
    logic        converte_bcd;
    logic [15:0] bcd = '0;
    logic        pronto_bcd = 1'b0;
    logic        tx_partida;
    logic [7:0]  tx_dado;
    logic        tx_pronto = 1'b0;
    logic        ocupado;
    logic        pronto;
    logic [1:0]  canal;

    logic        transmite1 = 1'b0;
    logic [11:0] medidas1 = '0;
    logic [11:0] medida_bin1;
    logic        converte_bcd1;
    logic [7:0]  bcd1 = '0;
    logic        pronto_bcd1 = 1'b0;
    logic        tx_partida1;
    logic [7:0]  tx_dado1;
    logic        tx_pronto1 = 1'b0;
    logic        ocupado1;
    logic        pronto1;
    logic [0:0]  canal1;

    int n_checks = 0;
    int n_pass   = 0;
    bq_t bytes0, bytes1;
    int pr0 = 0, pr1 = 0;
    int txc0 = 0, txc1 = 0, cvc0 = 0, cvc1 = 0;
    int val0 = 0, val1 = 0;

    transmissao_medidas_multicanal u_dut (
        .clock(clock), .reset(reset), .transmite(transmite), .medidas(medidas),
        .medida_bin(medida_bin), .converte_bcd(converte_bcd), .bcd(bcd),
        .pronto_bcd(pronto_bcd), .tx_partida(tx_partida), .tx_dado(tx_dado),
        .tx_pronto(tx_pronto), .ocupado(ocupado), .pronto(pronto), .canal(canal)
    );

    transmissao_medidas_multicanal #(.NUM_CANAIS(1), .DIGITOS(2)) u_dut1 (
        .clock(clock), .reset(reset), .transmite(transmite1), .medidas(medidas1),
        .medida_bin(medida_bin1), .converte_bcd(converte_bcd1), .bcd(bcd1),
        .pronto_bcd(pronto_bcd1), .tx_partida(tx_partida1), .tx_dado(tx_dado1),
        .tx_pronto(tx_pronto1), .ocupado(ocupado1), .pronto(pronto1), .canal(canal1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bq_t frame_de(input string s);
        bq_t q;
        logic [7:0] x = 8'h00;
        for (int i = 0; i < s.len(); i++) begin
            q.push_back(s[i]);
            x = x ^ s[i];
        end
`ifdef TRANSMISSAO_CHECKSUM_EN
        q.push_back(x);
`endif
        q.push_back(8'h23);
        return q;
    endfunction

    task automatic cmp_frame(input string tag, input bq_t got, input bq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
    endtask

    // Converter answers 3 cycles after the start pulse; TX finishes 10 cycles after tx_partida.
    always @(negedge clock) begin
        pronto_bcd = 1'b0;
        tx_pronto  = 1'b0;
        if (reset) begin
            cvc0 = 0;
            txc0 = 0;
        end else begin
            if (converte_bcd) begin
                val0 = int'(medida_bin);
                cvc0 = 3;
            end else if (cvc0 > 0) begin
                cvc0--;
                if (cvc0 == 0) begin
                    bcd = to_bcd(val0);
                    pronto_bcd = 1'b1;
                end
            end
            if (tx_partida) begin
                bytes0.push_back(tx_dado);
                txc0 = 10;
            end else if (txc0 > 0) begin
                txc0--;
                if (txc0 == 0) begin
                    check("tx_dado_estavel", tx_dado, bytes0[$]);
                    tx_pronto = 1'b1;
                end
            end
            if (pronto) pr0++;
        end
    end

    always @(negedge clock) begin
        pronto_bcd1 = 1'b0;
        tx_pronto1  = 1'b0;
        if (reset) begin
            cvc1 = 0;
            txc1 = 0;
        end else begin
            if (converte_bcd1) begin
                val1 = int'(medida_bin1);
                cvc1 = 3;
            end else if (cvc1 > 0) begin
                cvc1--;
                if (cvc1 == 0) begin
                    bcd1 = to_bcd(val1) & 16'h00FF;
                    pronto_bcd1 = 1'b1;
                end
            end
            if (tx_partida1) begin
                bytes1.push_back(tx_dado1);
                txc1 = 10;
            end else if (txc1 > 0) begin
                txc1--;
                if (txc1 == 0) tx_pronto1 = 1'b1;
            end
            if (pronto1) pr1++;
        end
    end

    task automatic pulse0();
        @(negedge clock); #1;
        transmite = 1'b1;
        @(negedge clock); #1;
        transmite = 1'b0;
    endtask

    task automatic wait_pr0(input int alvo, input string tag);
        int n = 0;
        while (pr0 < alvo && n < 3000) begin
            @(negedge clock); #1;
            n++;
        end
        check(tag, pr0, alvo);
    endtask

    task automatic wait_bytes0(input int alvo, input string tag);
        int n = 0;
        while (bytes0.size() < alvo && n < 3000) begin
            @(negedge clock); #1;
            n++;
        end
        check(tag, bytes0.size(), alvo);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bq_t exp0, exp1;
        int base, len0;
        exp0 = frame_de("0123,0007,4095,0000");
        len0 = exp0.size();
        medidas  = {12'd0, 12'd4095, 12'd7, 12'd123};
        medidas1 = 12'd42;

        repeat (3) @(negedge clock);
        #1;
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_tx_partida", tx_partida, 0);
        check("rst_converte", converte_bcd, 0);
        check("rst_tx_dado", tx_dado, 0);
        check("rst_canal", canal, 0);
        check("rst_medida_bin", medida_bin, 0);
        check("rst_ocupado1", ocupado1, 0);
        reset = 1'b0;

        // Basic frame
        pulse0();
        check("busy_after_start", ocupado, 1);
        wait_pr0(1, "frame1_pronto");
        cmp_frame("frame1", bytes0, exp0);
        check("frame1_pronto_pulse", pronto, 1);
        @(negedge clock); #1;
        check("frame1_ocupado_fim", ocupado, 0);
        check("frame1_pronto_once", pr0, 1);

        // transmite held high: exactly one frame, next only after IDLE
        bytes0.delete();
        @(negedge clock); #1;
        transmite = 1'b1;
        wait_pr0(2, "held_pronto");
        check("held_one_frame", bytes0.size(), len0);
        @(negedge clock); #1;
        check("held_idle_between", ocupado, 0);
        @(posedge clock); #1;
        transmite = 1'b0;
        check("held_restart", ocupado, 1);
        wait_pr0(3, "held_pronto2");
        check("held_two_frames", bytes0.size(), 2 * len0);
        @(negedge clock); #1;
        check("held_ocupado_fim", ocupado, 0);

        // Measurement change mid-frame uses the snapshot
        bytes0.delete();
        pulse0();
        wait_bytes0(2, "mid_wait");
        medidas[23:12] = 12'd9;
        wait_pr0(4, "mid_pronto");
        cmp_frame("mid", bytes0, exp0);
        medidas[23:12] = 12'd7;

        // Async reset while waiting on tx_pronto after the 6th byte
        bytes0.delete();
        base = pr0;
        pulse0();
        wait_bytes0(6, "rst_mid_wait");
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        check("rstmid_ocupado", ocupado, 0);
        check("rstmid_tx_dado", tx_dado, 0);
        check("rstmid_canal", canal, 0);
        check("rstmid_medida_bin", medida_bin, 0);
        check("rstmid_tx_partida", tx_partida, 0);
        @(negedge clock); #1;
        reset = 1'b0;
        repeat (15) @(negedge clock);
        #1;
        check("rstmid_no_pronto", pr0, base);
        check("rstmid_still_idle", ocupado, 0);
        bytes0.delete();
        pulse0();
        wait_pr0(base + 1, "rstmid_pronto");
        cmp_frame("after_rst", bytes0, exp0);

        // Single channel, two digits: no separator
        exp1.push_back(8'h34);
        exp1.push_back(8'h32);
`ifdef TRANSMISSAO_CHECKSUM_EN
        exp1.push_back(8'h06);
`endif
        exp1.push_back(8'h23);
        @(negedge clock); #1;
        transmite1 = 1'b1;
        @(negedge clock); #1;
        transmite1 = 1'b0;
        for (int n = 0; n < 3000 && pr1 < 1; n++) begin
            @(negedge clock); #1;
        end
        check("one_ch_pronto", pr1, 1);
        cmp_frame("one_ch", bytes1, exp1);
        @(negedge clock); #1;
        check("one_ch_ocupado_fim", ocupado1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
